// File: rtl/slt_arbiter_pkg.sv
// Shared definitions for slt_arbiter: FSM encoding, parameter defaults and a
// modular-increment helper used for the round-robin pointer.
package slt_arbiter_pkg;

  localparam int WIRE_DEF = 32;
  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  // (v + 1) mod n for 0 <= v < n, without a general divider.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after ptr_i, wrapping modulo NREQ. ptr_i must be below NREQ.
module rr_arbiter
  import slt_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o
);

  logic [IDW-1:0] cand [NREQ];

  // cand[k] is the requester examined k-th in priority order.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum      = {1'b0, ptr_i} + (IDW+1)'(gi);
      assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                : sum[IDW-1:0];
    end
  endgenerate

  always_comb begin
    logic found;
    found   = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && en_i && req_i[cand[k]]) begin
        found            = 1'b1;
        grant_o[cand[k]] = 1'b1;
        idx_o            = cand[k];
      end
    end
  end

endmodule

// File: rtl/slt.sv
// Sign-magnitude set-less-than: MSB is the sign, low WIRE-1 bits the magnitude.
// Result is 1 in bit 0 when a < b; upper bits are always zero.
module slt #(
  parameter int WIRE = 32
) (
  input  logic [WIRE-1:0] a_i,
  input  logic [WIRE-1:0] b_i,
  output logic [WIRE-1:0] y_o
);

  logic            sa;
  logic            sb;
  logic [WIRE-2:0] ma;
  logic [WIRE-2:0] mb;
  logic            lt;

  assign sa = a_i[WIRE-1];
  assign sb = b_i[WIRE-1];
  assign ma = a_i[WIRE-2:0];
  assign mb = b_i[WIRE-2:0];

  // -0 compares below +0, so sign alone decides whenever the signs differ.
  always_comb begin
    lt = 1'b0;
    case ({sa, sb})
      2'b10:   lt = 1'b1;
      2'b01:   lt = 1'b0;
      2'b00:   lt = (ma < mb);
      default: lt = (ma > mb);
    endcase
  end

  assign y_o = {{(WIRE-1){1'b0}}, lt};

endmodule

// File: rtl/slt_arbiter.sv
// Round-robin front end sharing one slt comparator among NREQ requesters.
// Optional macro SLT_ARBITER_UNSIGNED_EN adds req_uns for full-width unsigned compares.
module slt_arbiter
  import slt_arbiter_pkg::*;
#(
  parameter int WIRE = WIRE_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WIRE-1:0] req_a,
  input  logic [NREQ*WIRE-1:0] req_b,
`ifdef SLT_ARBITER_UNSIGNED_EN
  input  logic [NREQ-1:0]      req_uns,
`endif
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [WIRE-1:0]      resp_data,
  output logic                 busy
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [WIRE-1:0] a_q, a_d;
  logic [WIRE-1:0] b_q, b_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [WIRE-1:0] resp_data_q, resp_data_d;
`ifdef SLT_ARBITER_UNSIGNED_EN
  logic            uns_q, uns_d;
`endif

  logic [WIRE-1:0] a_arr [NREQ];
  logic [WIRE-1:0] b_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            arb_en;
  logic [WIRE-1:0] slt_y;
  logic [WIRE-1:0] cmp_y;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIRE +: WIRE];
      assign b_arr[gi] = req_b[gi*WIRE +: WIRE];
    end
  endgenerate

  // Grants only in IDLE and never while reset is asserted.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  slt #(
    .WIRE (WIRE)
  ) u_slt (
    .a_i (a_q),
    .b_i (b_q),
    .y_o (slt_y)
  );

`ifdef SLT_ARBITER_UNSIGNED_EN
  assign cmp_y = uns_q ? {{(WIRE-1){1'b0}}, (a_q < b_q)} : slt_y;
`else
  assign cmp_y = slt_y;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
`ifdef SLT_ARBITER_UNSIGNED_EN
    uns_d        = uns_q;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          a_d     = a_arr[grant_idx];
          b_d     = b_arr[grant_idx];
          id_d    = grant_idx;
`ifdef SLT_ARBITER_UNSIGNED_EN
          uns_d   = req_uns[grant_idx];
`endif
          state_d = CMP;
        end
      end
      CMP: begin
        resp_data_d  = cmp_y;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          ptr_d        = IDW'(wrap_inc(32'(id_q), NREQ));
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
`ifdef SLT_ARBITER_UNSIGNED_EN
      uns_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
`ifdef SLT_ARBITER_UNSIGNED_EN
      uns_q        <= uns_d;
`endif
    end
  end

  assign req_ready  = grant;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

endmodule
